// File: rtl/fsm_step_conditioner_if.sv
// Board-input bundle for the step conditioner: raw button/switch inputs in,
// conditioned step enable, switch vector and step count out.
interface fsm_step_conditioner_if;
   logic       btn_step_raw;
   logic [1:0] sw_raw;
   logic       auto_en_raw;
   logic       step_pulse;
   logic [1:0] sw_out;
   logic [7:0] step_count;

   // No handshake: raw inputs may change at any time, and all outputs are
   // registered and valid on every cycle (step_pulse is a one-cycle strobe).
   modport master (
      output btn_step_raw,
      output sw_raw,
      output auto_en_raw,
      input  step_pulse,
      input  sw_out,
      input  step_count
   );

   modport slave (
      input  btn_step_raw,
      input  sw_raw,
      input  auto_en_raw,
      output step_pulse,
      output sw_out,
      output step_count
   );
endinterface

// File: rtl/fsm_step_conditioner.sv
// Input stage for the lab Moore FSMs: synchronises and debounces the step button and
// mode switches, issues single-cycle step pulses (manual or auto) and counts them.
module fsm_step_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int AUTO_DIV        = 100
) (
   input  logic                         clk,
   input  logic                         reset,
   fsm_step_conditioner_if.slave        io,
   output logic                         dbg_step_state
);

   localparam int CW  = $clog2(DEBOUNCE_CYCLES);
   localparam int DW  = $clog2(AUTO_DIV);
   localparam int NDB = 3;   // debounced bits: [0]=button, [2:1]=switches
   localparam int AUTO_BIT = 3;
   localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(AUTO_DIV - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HELD = 1'b1
   } step_state_e;

   logic [3:0]     sync1_q, sync1_d;
   logic [3:0]     sync2_q, sync2_d;
   logic [NDB-1:0] stable_q, stable_d;
   logic [CW-1:0]  cnt_q [NDB];
   logic [CW-1:0]  cnt_d [NDB];
   step_state_e    state_q, state_d;
   logic [DW-1:0]  div_q, div_d;
   logic           step_pulse_q, step_pulse_d;
   logic [1:0]     sw_out_q, sw_out_d;
   logic [7:0]     step_count_q, step_count_d;

   logic           btn_db;
   logic           auto_sync;
   logic           manual_req;
   logic           auto_req;

   // Two-flop synchronisers; bit 3 carries the auto enable, which is not debounced.
   always_comb begin
      sync1_d = {io.auto_en_raw, io.sw_raw, io.btn_step_raw};
      sync2_d = sync1_q;
   end

   assign btn_db    = stable_q[0];
   assign auto_sync = sync2_q[AUTO_BIT];

   // A new level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_comb begin
      for (int i = 0; i < NDB; i++) begin
         stable_d[i] = stable_q[i];
         cnt_d[i]    = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == DB_LAST) begin
               stable_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
   end

   // Button FSM tracks presses even in auto mode so a release never fires a pulse.
   always_comb begin
      state_d    = state_q;
      manual_req = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (btn_db) begin
               state_d    = ST_HELD;
               manual_req = !auto_sync;
            end
         end
         ST_HELD: begin
            if (!btn_db) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      div_d    = '0;
      auto_req = 1'b0;
      if (auto_sync) begin
         if (div_q == DIV_LAST) begin
            auto_req = 1'b1;
         end else begin
            div_d = div_q + DW'(1);
         end
      end
   end

   // sw_out is frozen while a step is presented so the FSM sees a stable sw_in.
   always_comb begin
      step_pulse_d = manual_req | auto_req;
      sw_out_d     = step_pulse_q ? sw_out_q : stable_q[2:1];
      step_count_d = step_count_q + {7'd0, step_pulse_q};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         stable_q     <= '0;
         for (int i = 0; i < NDB; i++) begin
            cnt_q[i] <= '0;
         end
         state_q      <= ST_IDLE;
         div_q        <= '0;
         step_pulse_q <= 1'b0;
         sw_out_q     <= '0;
         step_count_q <= '0;
      end else begin
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         stable_q     <= stable_d;
         for (int i = 0; i < NDB; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         state_q      <= state_d;
         div_q        <= div_d;
         step_pulse_q <= step_pulse_d;
         sw_out_q     <= sw_out_d;
         step_count_q <= step_count_d;
      end
   end

   assign io.step_pulse  = step_pulse_q;
   assign io.sw_out      = sw_out_q;
   assign io.step_count  = step_count_q;
   assign dbg_step_state = (state_q == ST_HELD);

endmodule

// File: tb/tb_fsm_step_conditioner.sv
// Bench for fsm_step_conditioner: directed scenarios plus random soak, checked cycle by
// cycle against a behavioural model through an expected-output queue.
module tb_fsm_step_conditioner;

   localparam int DB = 4;
   localparam int AD = 5;

   logic clk = 1'b0;
   logic reset;
   logic dbg_state;

   fsm_step_conditioner_if io ();

   fsm_step_conditioner #(
      .DEBOUNCE_CYCLES(DB),
      .AUTO_DIV       (AD)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .io            (io),
      .dbg_step_state(dbg_state)
   );

   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   logic [10:0] exp_q[$];   // {step_pulse, sw_out, step_count}
   int checks = 0;
   int errors = 0;
   int dut_pulses = 0;
   int model_pulses = 0;
   logic [1:0] last_pulse_sw = 2'b00;

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d at t=%0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic [10:0] exp;
      logic [10:0] got;
      if (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         got = {io.step_pulse, io.sw_out, io.step_count};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL outputs t=%0t got pulse=%b sw=%b count=%0d expected pulse=%b sw=%b count=%0d",
                     $time, got[10], got[9:8], got[7:0], exp[10], exp[9:8], exp[7:0]);
         end
      end
      if (io.step_pulse === 1'b1) begin
         dut_pulses++;
         last_pulse_sw = io.sw_out;
      end
   end

   // ---------------- behavioural reference model ----------------
   // Raw inputs reach the conditioning logic two edges late; a level is accepted once the
   // last DB synchronised samples all disagree with it; a step fires on each rising edge of
   // the accepted button level (auto off) or every AD-th cycle of continuous auto enable.
   logic [3:0] m_pipe[$];   // raw samples in flight through the synchroniser
   logic [3:0] m_win[$];    // most recent synchronised samples, newest last
   logic [2:0] m_level;
   logic       m_btn_seen;
   int         m_auto_run;
   logic       m_pulse;
   logic [1:0] m_sw;
   logic [7:0] m_count;

   task automatic model_edge(input logic rst, input logic [3:0] raw);
      logic [3:0] s2;
      logic [2:0] lvl_old;
      logic       pulse_old;
      logic       manual;
      logic       auto_p;
      bit         all_differ;
      if (rst) begin
         m_pipe.delete();
         m_pipe.push_back(4'd0);
         m_pipe.push_back(4'd0);
         m_win.delete();
         m_level    = 3'd0;
         m_btn_seen = 1'b0;
         m_auto_run = 0;
         m_pulse    = 1'b0;
         m_sw       = 2'd0;
         m_count    = 8'd0;
      end else begin
         s2        = m_pipe.pop_front();
         m_pipe.push_back(raw);
         lvl_old   = m_level;
         pulse_old = m_pulse;
         m_win.push_back(s2);
         if (m_win.size() > DB) void'(m_win.pop_front());
         for (int b = 0; b < 3; b++) begin
            all_differ = (m_win.size() == DB);
            foreach (m_win[k]) if (m_win[k][b] == lvl_old[b]) all_differ = 0;
            if (all_differ) m_level[b] = s2[b];
         end
         manual     = lvl_old[0] && !m_btn_seen && !s2[3];
         m_btn_seen = lvl_old[0];
         m_auto_run = s2[3] ? m_auto_run + 1 : 0;
         auto_p     = s2[3] && (m_auto_run % AD == 0);
         m_count    = m_count + 8'(pulse_old);
         if (!pulse_old) m_sw = lvl_old[2:1];
         m_pulse    = manual || auto_p;
      end
      if (m_pulse) model_pulses++;
      exp_q.push_back({m_pulse, m_sw, m_count});
   endtask

   // ---------------- driver ----------------
   task automatic cycle();
      model_edge(reset, {io.auto_en_raw, io.sw_raw, io.btn_step_raw});
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   int win_dut;
   int win_model;

   task automatic open_window();
      win_dut   = dut_pulses;
      win_model = model_pulses;
   endtask

   task automatic close_window(input string name, input int spec_pulses);
      check({name, "_vs_model"}, dut_pulses - win_dut, model_pulses - win_model);
      check({name, "_pulses"}, dut_pulses - win_dut, spec_pulses);
   endtask

   task automatic press(input int hold, input int rel);
      io.btn_step_raw = 1'b1;
      cycles(hold);
      io.btn_step_raw = 1'b0;
      cycles(rel);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset           = 1'b1;
      io.btn_step_raw = 1'b1;
      io.sw_raw       = 2'b11;
      io.auto_en_raw  = 1'b0;
      @(negedge clk);
      #1;

      // 1: reset with inputs held high, then release
      open_window();
      cycle();
      check("reset_outputs", int'({io.step_pulse, io.sw_out, io.step_count}), 0);
      cycles(2);
      reset = 1'b0;
      cycles(12);
      check("t1_sw_out", int'(io.sw_out), 3);
      io.btn_step_raw = 1'b0;
      cycles(10);
      close_window("t1", 1);

      // 2: clean press held 20 cycles
      open_window();
      press(20, 12);
      close_window("t2", 1);

      // 3: bounce then hold
      open_window();
      io.btn_step_raw = 1'b1; cycle();
      io.btn_step_raw = 1'b0; cycle();
      io.btn_step_raw = 1'b1; cycle();
      io.btn_step_raw = 1'b0; cycle();
      press(12, 12);
      close_window("t3", 1);

      // 4: switch change landing on the pulse cycle
      io.sw_raw = 2'b01;
      cycles(10);
      open_window();
      io.btn_step_raw = 1'b1;
      cycle();
      io.sw_raw = 2'b10;
      cycles(15);
      io.btn_step_raw = 1'b0;
      cycles(12);
      close_window("t4", 1);
      check("t4_sw_at_pulse", int'(last_pulse_sw), 1);
      check("t4_sw_after", int'(io.sw_out), 2);

      // 5: auto mode with a press mid-run
      open_window();
      io.auto_en_raw = 1'b1;
      cycles(8);
      io.btn_step_raw = 1'b1;
      cycles(14);
      io.auto_en_raw = 1'b0;
      cycles(10);
      io.btn_step_raw = 1'b0;
      cycles(12);
      close_window("t5", 4);

      // 6: 257 randomised presses wrap the counter
      reset = 1'b1;
      cycles(2);
      reset = 1'b0;
      cycles(2);
      open_window();
      for (int p = 0; p < 257; p++) begin
         io.sw_raw = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) begin
            io.btn_step_raw = 1'b1; cycle();
            io.btn_step_raw = 1'b0; cycle();
         end
         press($urandom_range(6, 10), $urandom_range(6, 10));
      end
      cycles(4);
      close_window("t6", 257);
      check("t6_count_wrap", int'(io.step_count), 1);

      // 6b: reset in the middle of a debounce run
      open_window();
      io.btn_step_raw = 1'b1;
      cycles(3);
      reset = 1'b1;
      io.btn_step_raw = 1'b0;
      cycle();
      reset = 1'b0;
      cycles(12);
      close_window("t6_reset", 0);

      // random soak
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 5) == 0) io.btn_step_raw = ~io.btn_step_raw;
         if ($urandom_range(0, 9) == 0) io.sw_raw[0] = ~io.sw_raw[0];
         if ($urandom_range(0, 9) == 0) io.sw_raw[1] = ~io.sw_raw[1];
         if ($urandom_range(0, 39) == 0) io.auto_en_raw = ~io.auto_en_raw;
         reset = ($urandom_range(0, 199) == 0);
         cycle();
      end
      reset = 1'b0;
      cycles(2);

      check("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
